// File: rtl/universal_shift_register_n.sv
// rtl/universal_shift_register_n.sv - parametrised universal shift/rotate register with word-shift counter
// Optional registered even parity on parallel_out when USR_PARITY_EN is defined.
module universal_shift_register_n #(
   parameter int WIDTH = 8,
   localparam int CW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [2:0]       mode,
   input  logic             serial_in_r,
   input  logic             serial_in_l,
   input  logic [WIDTH-1:0] parallel_in,
   output logic [WIDTH-1:0] parallel_out,
   output logic             serial_out_r,
   output logic             serial_out_l,
   output logic [CW-1:0]    shift_cnt,
   output logic             word_done,
   output logic             parity_out
);

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SHR  = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_LOAD = 3'b011;
   localparam logic [2:0] M_ROR  = 3'b100;
   localparam logic [2:0] M_ROL  = 3'b101;
   localparam logic [2:0] M_ASR  = 3'b110;
   localparam logic [2:0] M_CLR  = 3'b111;

   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] next_q;
   logic             next_sr;
   logic             next_sl;
   logic [CW-1:0]    next_cnt;
   logic             next_done;
   logic             is_shift;

   always_comb begin
      next_q    = parallel_out;
      next_sr   = serial_out_r;
      next_sl   = serial_out_l;
      next_cnt  = shift_cnt;
      next_done = 1'b0;
      is_shift  = 1'b0;
      if (enable) begin
         case (mode)
            M_HOLD: ;
            M_SHR: begin
               next_q   = {serial_in_r, parallel_out[WIDTH-1:1]};
               next_sr  = parallel_out[0];
               is_shift = 1'b1;
            end
            M_SHL: begin
               next_q   = {parallel_out[WIDTH-2:0], serial_in_l};
               next_sl  = parallel_out[WIDTH-1];
               is_shift = 1'b1;
            end
            M_LOAD: begin
               next_q   = parallel_in;
               next_cnt = '0;
            end
            M_ROR: begin
               next_q   = {parallel_out[0], parallel_out[WIDTH-1:1]};
               next_sr  = parallel_out[0];
               is_shift = 1'b1;
            end
            M_ROL: begin
               next_q   = {parallel_out[WIDTH-2:0], parallel_out[WIDTH-1]};
               next_sl  = parallel_out[WIDTH-1];
               is_shift = 1'b1;
            end
            M_ASR: begin
               next_q   = {parallel_out[WIDTH-1], parallel_out[WIDTH-1:1]};
               next_sr  = parallel_out[0];
               is_shift = 1'b1;
            end
            M_CLR: begin
               next_q   = '0;
               next_sr  = 1'b0;
               next_sl  = 1'b0;
               next_cnt = '0;
            end
            default: ;
         endcase
         // Every shift-type mode advances the same counter, regardless of direction.
         if (is_shift) begin
            if (shift_cnt == CNT_LAST) begin
               next_cnt  = '0;
               next_done = 1'b1;
            end else begin
               next_cnt = shift_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         parallel_out <= '0;
         serial_out_r <= 1'b0;
         serial_out_l <= 1'b0;
         shift_cnt    <= '0;
         word_done    <= 1'b0;
      end else begin
         parallel_out <= next_q;
         serial_out_r <= next_sr;
         serial_out_l <= next_sl;
         shift_cnt    <= next_cnt;
         word_done    <= next_done;
      end
   end

`ifdef USR_PARITY_EN
   // Computed from next_q so parity lines up with the registered parallel_out.
   always_ff @(posedge clk) begin
      if (reset) begin
         parity_out <= 1'b0;
      end else begin
         parity_out <= ^next_q;
      end
   end
`else
   assign parity_out = 1'b0;
`endif

endmodule

// File: tb/tb_universal_shift_register_n.sv
// tb/tb_universal_shift_register_n.sv - directed self-checking bench for universal_shift_register_n
module tb_universal_shift_register_n;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [2:0] mode;
   logic       serial_in_r;
   logic       serial_in_l;
   logic [7:0] parallel_in;
   logic [7:0] parallel_out;
   logic       serial_out_r;
   logic       serial_out_l;
   logic [2:0] shift_cnt;
   logic       word_done;
   logic       parity_out;

   int checks = 0;
   int errors = 0;

   universal_shift_register_n #(.WIDTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .mode         (mode),
      .serial_in_r  (serial_in_r),
      .serial_in_l  (serial_in_l),
      .parallel_in  (parallel_in),
      .parallel_out (parallel_out),
      .serial_out_r (serial_out_r),
      .serial_out_l (serial_out_l),
      .shift_cnt    (shift_cnt),
      .word_done    (word_done),
      .parity_out   (parity_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] val);
      enable = 1'b1; mode = 3'b011; parallel_in = val;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; mode = 3'b011; parallel_in = 8'hA5;
      step();
      checks++;
      if ({parallel_out, serial_out_r, serial_out_l, shift_cnt, word_done, parity_out} !== 15'h0) begin
         errors++;
         $display("FAIL reset_state: got po=%h sr=%b sl=%b cnt=%0d done=%b par=%b expected all zero",
                  parallel_out, serial_out_r, serial_out_l, shift_cnt, word_done, parity_out);
      end
      reset = 1'b0;
      step();
      checks++;
      if (parallel_out !== 8'hA5) begin
         errors++; $display("FAIL load_after_reset: got %h expected a5", parallel_out);
      end
      checks++;
      if (shift_cnt !== 3'd0) begin
         errors++; $display("FAIL load_cnt: got %0d expected 0", shift_cnt);
      end
      checks++;
      if (parity_out !== 1'b0) begin
         errors++; $display("FAIL load_parity: got %b expected 0", parity_out);
      end
   endtask

   task automatic test_shift_right();
      logic [7:0] seq;
      seq = 8'hA5;
      load(8'hA5);
      mode = 3'b001; serial_in_r = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (serial_out_r !== seq[i]) begin
            errors++; $display("FAIL shr_serial_out[%0d]: got %b expected %b", i, serial_out_r, seq[i]);
         end
         checks++;
         if (shift_cnt !== 3'((i + 1) % 8)) begin
            errors++; $display("FAIL shr_cnt[%0d]: got %0d expected %0d", i, shift_cnt, (i + 1) % 8);
         end
         checks++;
         if (word_done !== (i == 7)) begin
            errors++; $display("FAIL shr_word_done[%0d]: got %b expected %b", i, word_done, i == 7);
         end
      end
      checks++;
      if (parallel_out !== 8'hFF) begin
         errors++; $display("FAIL shr_final: got %h expected ff", parallel_out);
      end
      // Load right after the 8th shift: the pulse is already out and drops next cycle.
      load(8'h00);
      checks++;
      if (word_done !== 1'b0) begin
         errors++; $display("FAIL shr_pulse_width: got %b expected 0", word_done);
      end
   endtask

   task automatic test_rotate_arith();
      load(8'h81);
      mode = 3'b101;
      step();
      checks++;
      if (parallel_out !== 8'h03 || serial_out_l !== 1'b1) begin
         errors++; $display("FAIL rol: got po=%h sl=%b expected po=03 sl=1", parallel_out, serial_out_l);
      end
      load(8'h80);
      mode = 3'b110;
      step(); step(); step();
      checks++;
      if (parallel_out !== 8'hF0 || serial_out_r !== 1'b0 || shift_cnt !== 3'd3) begin
         errors++; $display("FAIL asr: got po=%h sr=%b cnt=%0d expected po=f0 sr=0 cnt=3",
                            parallel_out, serial_out_r, shift_cnt);
      end
   endtask

   task automatic test_enable_gating();
      load(8'hFC);
      mode = 3'b010; serial_in_l = 1'b0;
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (parallel_out !== 8'h80 || shift_cnt !== 3'd5 || serial_out_l !== 1'b1) begin
         errors++; $display("FAIL shl_pre: got po=%h cnt=%0d sl=%b expected po=80 cnt=5 sl=1",
                            parallel_out, shift_cnt, serial_out_l);
      end
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (parallel_out !== 8'h80 || shift_cnt !== 3'd5 || serial_out_l !== 1'b1 ||
             serial_out_r !== 1'b0 || word_done !== 1'b0) begin
            errors++; $display("FAIL enable_freeze[%0d]: got po=%h cnt=%0d sl=%b sr=%b done=%b expected po=80 cnt=5 sl=1 sr=0 done=0",
                               i, parallel_out, shift_cnt, serial_out_l, serial_out_r, word_done);
         end
      end
      enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (word_done !== (i == 2)) begin
            errors++; $display("FAIL resume_done[%0d]: got %b expected %b", i, word_done, i == 2);
         end
      end
      checks++;
      if (parallel_out !== 8'h00 || shift_cnt !== 3'd0 || serial_out_l !== 1'b0) begin
         errors++; $display("FAIL resume_final: got po=%h cnt=%0d sl=%b expected po=00 cnt=0 sl=0",
                            parallel_out, shift_cnt, serial_out_l);
      end
      mode = 3'b000;
      step();
      checks++;
      if (word_done !== 1'b0 || shift_cnt !== 3'd0) begin
         errors++; $display("FAIL hold_after_word: got done=%b cnt=%0d expected done=0 cnt=0", word_done, shift_cnt);
      end
   endtask

   task automatic test_mid_reset();
      load(8'h5A);
      mode = 3'b001; serial_in_r = 1'b1;
      for (int i = 0; i < 7; i++) step();
      checks++;
      if (shift_cnt !== 3'd7) begin
         errors++; $display("FAIL mid_pre_cnt: got %0d expected 7", shift_cnt);
      end
      reset = 1'b1;
      step();
      checks++;
      if ({parallel_out, serial_out_r, serial_out_l, shift_cnt, word_done, parity_out} !== 15'h0) begin
         errors++; $display("FAIL mid_reset: got po=%h sr=%b sl=%b cnt=%0d done=%b par=%b expected all zero",
                            parallel_out, serial_out_r, serial_out_l, shift_cnt, word_done, parity_out);
      end
      reset = 1'b0; mode = 3'b000;
      step();
      checks++;
      if (word_done !== 1'b0 || shift_cnt !== 3'd0) begin
         errors++; $display("FAIL mid_reset_after: got done=%b cnt=%0d expected done=0 cnt=0", word_done, shift_cnt);
      end
   endtask

   task automatic test_clear();
      load(8'hF4);
      mode = 3'b100;
      step(); step(); step();
      mode = 3'b010; serial_in_l = 1'b0;
      step();
      checks++;
      if (parallel_out !== 8'h3C || shift_cnt !== 3'd4 || serial_out_r !== 1'b1 || serial_out_l !== 1'b1) begin
         errors++; $display("FAIL clear_pre: got po=%h cnt=%0d sr=%b sl=%b expected po=3c cnt=4 sr=1 sl=1",
                            parallel_out, shift_cnt, serial_out_r, serial_out_l);
      end
      mode = 3'b111;
      step();
      checks++;
      if (parallel_out !== 8'h00 || shift_cnt !== 3'd0 || serial_out_r !== 1'b0 ||
          serial_out_l !== 1'b0 || word_done !== 1'b0) begin
         errors++; $display("FAIL clear: got po=%h cnt=%0d sr=%b sl=%b done=%b expected all zero",
                            parallel_out, shift_cnt, serial_out_r, serial_out_l, word_done);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q;
      logic       exp_par;
      load(8'h00);
      exp_q = 8'h00;
      mode = 3'b010; serial_in_l = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         exp_q = {exp_q[6:0], 1'b1};
         checks++;
         if (word_done !== (i == 7 || i == 15)) begin
            errors++; $display("FAIL b2b_done[%0d]: got %b expected %b", i, word_done, i == 7 || i == 15);
         end
         checks++;
         if (parallel_out !== exp_q || shift_cnt !== 3'((i + 1) % 8)) begin
            errors++; $display("FAIL b2b_state[%0d]: got po=%h cnt=%0d expected po=%h cnt=%0d",
                               i, parallel_out, shift_cnt, exp_q, (i + 1) % 8);
         end
`ifdef USR_PARITY_EN
         exp_par = ^exp_q;
`else
         exp_par = 1'b0;
`endif
         checks++;
         if (parity_out !== exp_par) begin
            errors++; $display("FAIL b2b_parity[%0d]: got %b expected %b", i, parity_out, exp_par);
         end
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; mode = 3'b000;
      serial_in_r = 1'b0; serial_in_l = 1'b0; parallel_in = 8'h00;
      test_reset();
      test_shift_right();
      test_rotate_arith();
      test_enable_gating();
      test_mid_reset();
      test_clear();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
